// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up/down counter with wrap or one-shot (stop at terminal) mode.
// Define MOD_COUNTER_WRAPCNT_EN to add the saturating terminal-event counter on port wraps.
module mod_counter #(
   parameter int WIDTH   = 6,
   parameter int MODULUS = 53
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic             oneshot,
   output logic [WIDTH-1:0] cnt,
   output logic             z,
`ifdef MOD_COUNTER_WRAPCNT_EN
   output logic [7:0]       wraps,
`endif
   output logic             busy
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   typedef enum logic {RUN, DONE} state_t;

   state_t           state;
   logic             terminal;
   logic             term_event;
   logic [WIDTH-1:0] load_clamped;

   // Direction is sampled every edge, so the terminal value follows up immediately.
   always_comb begin
      terminal     = up ? (cnt == MAX) : (cnt == '0);
      term_event   = !clr && !load && (state == RUN) && en && terminal;
      load_clamped = (load_val > MAX) ? MAX : load_val;
   end

   assign busy = (state == RUN);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
         z     <= 1'b0;
      end else begin
         z <= term_event;
         if (clr) begin
            state <= RUN;
            cnt   <= '0;
         end else if (load) begin
            state <= RUN;
            cnt   <= load_clamped;
         end else if (state == RUN && en) begin
            if (!terminal) begin
               cnt <= up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
            end else if (oneshot) begin
               state <= DONE;
            end else begin
               cnt <= up ? '0 : MAX;
            end
         end
      end
   end

`ifdef MOD_COUNTER_WRAPCNT_EN
   // Counts terminal events (one per z pulse); load deliberately leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wraps <= '0;
      end else if (clr) begin
         wraps <= '0;
      end else if (term_event && wraps != 8'hFF) begin
         wraps <= wraps + 8'd1;
      end
   end
`endif

endmodule
